// File: rtl/instr_memory.sv
// instr_memory: byte-wide instruction store with a load port and a 10-byte
// fetch window. A fetch is read as five 16-bit beats, one beat per clock.
//
// Optional feature: define IMEM_BOUNDS_CHECK_EN to reject fetches whose
// 10-byte window does not fit inside the store (mem_error response).
// Without it, byte addresses wrap modulo MEM_BYTES and mem_error stays 0.
//
// Handshake: req is sampled on a rising edge only while busy=0. An accepted
// req raises busy on that edge. The result is presented by a one-cycle
// instr_valid pulse, and mem_error is meaningful only in that cycle. instr
// then holds its value until the next accepted req. A req asserted during
// the instr_valid cycle is accepted on the following edge.
module instr_memory #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [63:0]       PC,
    output logic              busy,
    output logic              instr_valid,
    output logic [0:79]       instr,
    output logic              mem_error,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data
);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_e;

    state_e            state_q;
    logic [2:0]        beat_q;
    logic [ADDR_W-1:0] pc_q;
    logic              busy_q;
    logic              instr_valid_q;
    logic              mem_error_q;
    logic [0:79]       instr_q;

    // Instruction store; contents survive reset.
    logic [7:0]        mem_q [MEM_BYTES];

    // Byte addresses for the current beat. Truncation to ADDR_W bits gives
    // the modulo-MEM_BYTES wrap (MEM_BYTES is 2**ADDR_W).
    logic [ADDR_W-1:0] beat_off;
    logic [ADDR_W-1:0] rd_addr_hi;
    logic [ADDR_W-1:0] rd_addr_lo;
    logic              req_oor;

    assign beat_off   = ADDR_W'({beat_q, 1'b0});
    assign rd_addr_hi = pc_q + beat_off;
    assign rd_addr_lo = rd_addr_hi + ADDR_W'(1);

`ifdef IMEM_BOUNDS_CHECK_EN
    // Out of range when any upper PC bit is set or the last byte (PC+9)
    // runs past the end of the store.
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(MEM_BYTES - 1);
    logic [ADDR_W:0] last_byte;
    assign last_byte = {1'b0, PC[ADDR_W-1:0]} + (ADDR_W+1)'(9);
    assign req_oor   = (|PC[63:ADDR_W]) || (last_byte > LAST_ADDR);
`else
    // Upper PC bits are deliberately ignored when addresses wrap.
    logic unused_pc_hi;
    assign unused_pc_hi = ^PC[63:ADDR_W];
    assign req_oor      = 1'b0;
`endif

    // Load port: writes land on every enabled edge, including during reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Fetch FSM: accept in IDLE, then five READ beats filling instr MSB-first.
    // Beat reads see pre-write memory because the store updates via NBA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            beat_q        <= 3'd0;
            pc_q          <= '0;
            busy_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            mem_error_q   <= 1'b0;
            instr_q       <= '0;
        end else begin
            instr_valid_q <= 1'b0;
            mem_error_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        instr_q <= '0;
                        if (req_oor) begin
                            instr_valid_q <= 1'b1;
                            mem_error_q   <= 1'b1;
                        end else begin
                            pc_q    <= PC[ADDR_W-1:0];
                            beat_q  <= 3'd0;
                            busy_q  <= 1'b1;
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    instr_q[16*beat_q +: 16] <= {mem_q[rd_addr_hi], mem_q[rd_addr_lo]};
                    if (beat_q == 3'd4) begin
                        beat_q        <= 3'd0;
                        busy_q        <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        beat_q <= beat_q + 3'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign mem_error   = mem_error_q;

endmodule

// File: tb/tb_instr_memory.sv
// Bench for instr_memory: reference byte model, expected-result queue filled
// at request time, monitor popping on every instr_valid pulse.
`timescale 1ns/1ps
module tb_instr_memory;

    localparam int MEM_BYTES = 1024;
    localparam int ADDR_W    = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req = 1'b0;
    logic [63:0]       pc = '0;
    logic              busy;
    logic              instr_valid;
    logic [0:79]       instr;
    logic              mem_error;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [7:0]        wr_data = '0;

    logic [7:0]        ref_mem [MEM_BYTES];
    logic [80:0]       exp_q [$];
    int                n_checks = 0;
    int                n_pass = 0;

    // Clock / reset block
    always #5 clk = ~clk;

    instr_memory #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .PC(pc),
        .busy(busy),
        .instr_valid(instr_valid),
        .instr(instr),
        .mem_error(mem_error),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [80:0] got, input logic [80:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_oor(input logic [63:0] a);
        bit oor_raw;
        oor_raw = (a[63:10] != 54'd0) || (int'(a[9:0]) + 9 > MEM_BYTES - 1);
`ifdef IMEM_BOUNDS_CHECK_EN
        return oor_raw;
`else
        return 1'b0;
`endif
    endfunction

    // Expected {mem_error, instr}; byte at PC is the most significant byte.
    function automatic logic [80:0] model(input logic [63:0] a);
        logic [79:0] r;
        logic [63:0] p;
        r = '0;
        if (is_oor(a)) return {1'b1, 80'h0};
        for (int k = 0; k < 10; k++) begin
            p = a + 64'(k);
            r[79-8*k -: 8] = ref_mem[p[9:0]];
        end
        return {1'b0, r};
    endfunction

    // Monitor: every instr_valid pulse must match the oldest expectation.
    always @(posedge clk) begin
        logic [80:0] e;
        #1;
        if (instr_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 81'd1, 81'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_instr", {1'b0, instr}, {1'b0, e[79:0]});
                check("sb_mem_error", {80'd0, mem_error}, {80'd0, e[80]});
            end
        end
    end

    task automatic write_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Single fetch; optionally writes wd to wa so it is sampled on edge N+wr_at.
    task automatic fetch(input logic [63:0] a, input int wr_at,
                         input logic [ADDR_W-1:0] wa, input logic [7:0] wd);
        int lat;
        int bcnt;
        int exp_lat;
        exp_q.push_back(model(a));
        exp_lat = is_oor(a) ? 1 : 5;
        pc = a;
        req = 1'b1;
        tick();
        req = 1'b0;
        pc = {$urandom, $urandom};
        lat = 0;
        bcnt = 0;
        while (!instr_valid && lat < 12) begin
            bcnt += int'(busy);
            if (lat + 1 == wr_at) begin
                wr_en = 1'b1;
                wr_addr = wa;
                wr_data = wd;
            end
            tick();
            lat++;
            if (wr_en) begin
                wr_en = 1'b0;
                ref_mem[wa] = wd;
            end
        end
        check("fetch_latency", 81'(lat), 81'(exp_lat));
        check("busy_cycles", 81'(bcnt), (exp_lat == 5) ? 81'd5 : 81'd0);
        check("busy_at_valid", {80'd0, busy}, 81'd0);
    endtask

    initial begin
        int nv;
        int first_v;
        int last_v;
        logic [63:0] a;

        // Load the store while reset is held: writes must still land.
        for (int i = 0; i < MEM_BYTES; i++) begin
            write_byte(ADDR_W'(i), 8'($urandom_range(0, 255)));
        end
        write_byte(10'd32, 8'h61); write_byte(10'd33, 8'h23);
        write_byte(10'd34, 8'h20); write_byte(10'd35, 8'h34);
        write_byte(10'd36, 8'h25); write_byte(10'd37, 8'h53);
        for (int i = 38; i < 42; i++) write_byte(ADDR_W'(i), 8'h00);

        check("rst_busy", {80'd0, busy}, 81'd0);
        check("rst_valid", {80'd0, instr_valid}, 81'd0);
        check("rst_mem_error", {80'd0, mem_error}, 81'd0);
        check("rst_instr", {1'b0, instr}, 81'd0);

        rst_n = 1'b1;
        tick();

        // Basic fetch
        fetch(64'd32, -1, '0, '0);
        check("basic_instr", {1'b0, instr}, {1'b0, 80'h6123_2034_2553_0000_0000});
        tick();
        check("basic_hold", {1'b0, instr}, {1'b0, 80'h6123_2034_2553_0000_0000});

        // Back-to-back with req held; PC disturbed mid-READ
        for (int i = 0; i < 3; i++) exp_q.push_back(model(64'd34));
        pc = 64'd34;
        req = 1'b1;
        tick();
        nv = 0; first_v = -1; last_v = -1;
        for (int i = 1; i < 18; i++) begin
            tick();
            if (i % 6 == 2) pc = 64'd0;
            if (i % 6 == 4) pc = 64'd34;
            if (instr_valid) begin
                nv++;
                if (first_v < 0) first_v = i;
                last_v = i;
            end
        end
        req = 1'b0;
        check("b2b_count", 81'(nv), 81'd3);
        check("b2b_first", 81'(first_v), 81'd5);
        check("b2b_last", 81'(last_v), 81'd17);
        check("b2b_prefix", {41'd0, instr[0:39]}, {41'd0, 40'h20_3425_5300});
        repeat (2) tick();

        // Bounds check / wrap at the top of the store
        fetch(64'd1020, -1, '0, '0);
`ifdef IMEM_BOUNDS_CHECK_EN
        check("oor_err", {80'd0, mem_error}, 81'd1);
        check("oor_instr", {1'b0, instr}, 81'd0);
`else
        check("wrap_err", {80'd0, mem_error}, 81'd0);
`endif
        tick();

        // Reset during beat 2: outputs clear at once, no pulse follows
        pc = 64'd32;
        req = 1'b1;
        tick();
        req = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {80'd0, busy}, 81'd0);
        check("midrst_valid", {80'd0, instr_valid}, 81'd0);
        check("midrst_instr", {1'b0, instr}, 81'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        nv = 0;
        repeat (8) begin
            tick();
            if (instr_valid) nv++;
        end
        check("midrst_no_pulse", 81'(nv), 81'd0);
        fetch(64'd32, -1, '0, '0);
        check("post_rst_instr", {1'b0, instr}, {1'b0, 80'h6123_2034_2553_0000_0000});
        tick();

        // Write to byte 40 on the beat-4 edge: old data returned, new next time
        fetch(64'd32, 5, 10'd40, 8'hFF);
        check("wdr_old", {73'd0, instr[64:71]}, 81'h00);
        tick();
        fetch(64'd32, -1, '0, '0);
        check("wdr_new", {73'd0, instr[64:71]}, 81'hFF);
        tick();

        // Upper address bits set
        fetch(64'h1_0000_0020, -1, '0, '0);
`ifdef IMEM_BOUNDS_CHECK_EN
        check("upper_err", {80'd0, mem_error}, 81'd1);
`else
        check("upper_wrap", {1'b0, instr}, {1'b0, 80'h6123_2034_2553_0000_FF00});
`endif
        tick();

        // Random fetches over random contents
        repeat (6) begin
            a = 64'($urandom_range(0, MEM_BYTES - 1));
            fetch(a, -1, '0, '0);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        check("scoreboard_empty", 81'(exp_q.size()), 81'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_memory.md
INSTR_MEMORY -- requirements
Module: instr_memory

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024: byte capacity of the instruction store.
REQ-002 SHALL have parameter ADDR_W, default 10: load-port address width, log2(MEM_BYTES).
REQ-003 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port req, input, 1: fetch request, sampled on rising edge.
REQ-006 SHALL have port PC, input, 64: byte address of first instruction byte.
REQ-007 SHALL have port busy, output, 1: high while a fetch is in progress.
REQ-008 SHALL have port instr_valid, output, 1: one-cycle pulse, instr and mem_error valid.
REQ-009 SHALL have port instr, output, 80, indexed [0:79]: 10-byte instruction window.
REQ-010 SHALL have port mem_error, output, 1: address out of range, qualified by instr_valid.
REQ-011 SHALL have port wr_en, input, 1: load-port byte write enable.
REQ-012 SHALL have port wr_addr, input, ADDR_W: load-port byte address.
REQ-013 SHALL have port wr_data, input, 8: load-port byte data.

Function
REQ-014 SHALL store MEM_BYTES bytes and write wr_data to wr_addr on every rising edge with wr_en=1, in any state.
REQ-015 SHALL implement states IDLE and READ, plus a 3-bit beat counter 0..4.
REQ-016 SHALL, in IDLE with req=1 at edge N, latch PC, clear instr, enter READ with beat=0 and set busy=1.
REQ-017 SHALL, at each READ edge, read bytes PC+2*beat and PC+2*beat+1 into instr[16*beat +: 16], lower address in the more significant byte (instr[0:7] = byte at PC).
REQ-018 SHALL, at the edge completing beat 4 (edge N+5), return to IDLE, clear busy and set instr_valid=1 for exactly one cycle.
REQ-019 SHALL hold instr stable from the instr_valid edge until the next accepted req.
REQ-020 SHALL ignore req while busy=1; there is no queueing.
REQ-021 SHALL accept a req asserted in the instr_valid cycle, giving back-to-back fetches every 6 cycles.
REQ-022 SHALL return pre-write contents to a read beat whose edge coincides with a write to the same address.
REQ-023 SHALL keep mem_error=0 whenever the bounds check is compiled out.

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE, beat=0, busy=0, instr_valid=0, mem_error=0 and instr=0.
REQ-025 SHALL abort a fetch when rst_n falls mid-READ, with no instr_valid pulse for that fetch.
REQ-026 SHALL leave stored bytes unchanged by reset.
REQ-027 SHALL not block load-port writes during reset.

Configuration
REQ-028 SHALL, with IMEM_BOUNDS_CHECK_EN defined, treat a req as out of range if PC[63:ADDR_W] != 0 or PC+9 > MEM_BYTES-1.
REQ-029 SHALL respond to an out-of-range req, with IMEM_BOUNDS_CHECK_EN defined, without entering READ: at edge N+1 instr_valid=1, mem_error=1, instr=0, busy stays 0.
REQ-030 SHALL, without IMEM_BOUNDS_CHECK_EN, form every byte address as (PC+k) mod MEM_BYTES, so reads wrap with no error indication.

Verification
REQ-031 SHALL cover a basic fetch: load bytes 32..41 = 61 23 20 34 25 53 00 00 00 00, req with PC=32 -> busy high for 5 cycles, then instr_valid pulse with instr=0x6123_2034_2553_0000_0000.
REQ-032 SHALL cover back-to-back and busy-ignored requests: req held high with PC=34 -> instr_valid every 6 cycles with instr starting 0x2034_2553_00; PC changed to 0 mid-READ has no effect.
REQ-033 SHALL cover the bounds check: PC=1020 with IMEM_BOUNDS_CHECK_EN -> instr_valid and mem_error at N+1, instr=0; without it -> instr = bytes 1020..1023,0..5 at N+5 and mem_error=0.
REQ-034 SHALL cover reset mid-operation: rst_n low at beat 2 -> busy, instr_valid and instr read 0 immediately, no instr_valid pulse, and a fresh req after release completes normally.
REQ-035 SHALL cover write during read: write 0xFF to byte 40 at the beat-4 edge of a PC=32 fetch -> instr byte 8 holds the old value 0x00, and the next fetch returns 0xFF.
REQ-036 SHALL cover an upper-address error: PC=64'h1_0000_0020 with IMEM_BOUNDS_CHECK_EN -> mem_error=1; without it -> wraps to bytes 32..41.
